program_loader: RTL

Byte-stream program loader that fills the processor's instruction memory before execution. It accepts a framed byte stream from a UART receiver over a valid/ready handshake and assembles little-endian 32-bit words. Each completed word is written to instruction memory through the memory's write-enable/data port. The processor core is held in reset until a complete, checksum-verified image is loaded.

---
 rtl/program_loader_pkg.sv | 25 ++
 rtl/program_loader_gap.sv | 32 +++
 rtl/program_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package program_loader_pkg;

    // Loader states; DONE is the only state that releases the core.
    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // Default frame start byte.
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Width of the running payload checksum (modular byte sum).
    localparam int unsigned CSUM_W = 8;

    // States in which the inter-byte gap timer runs.
    function automatic logic gap_counted(input state_t s);
        return (s == S_COUNT) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/program_loader_gap.sv
// Inter-byte gap timer: counts idle enabled cycles and flags the cycle whose
// closing edge would bring the idle count to TIMEOUT.
module gap_timer #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Expiry is seen combinationally so the FSM leaves on the TIMEOUT-th idle edge.
    assign expired = enable && !clear && (count == LAST);

    // Idle-cycle counter, cleared on any accepted byte or while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (SYNC, N, 4*N payload bytes,
// checksum), writes little-endian words to instruction memory and holds the
// core in reset until the image is verified.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 100000,
    parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    // One extra bit so a full 2^ADDR_W-word image can be counted.
    localparam int unsigned      WC_W      = ADDR_W + 1;
    localparam logic [WC_W-1:0]  MAX_WORDS = WC_W'(1) << ADDR_W;

    state_t            state;
    logic [WC_W-1:0]   word_cnt;
    logic [WC_W-1:0]   n_words;
    logic [WC_W-1:0]   word_cnt_inc;
    logic [WC_W-1:0]   n_decoded;
    logic              n_too_big;
    logic [1:0]        byte_idx;
    logic [23:0]       word_reg;
    logic [CSUM_W-1:0] csum;
    logic              fire;
    logic              timer_en;
    logic              timer_clear;
    logic              timer_expired;

    assign fire         = rx_valid && rx_ready;
    assign word_cnt_inc = word_cnt + WC_W'(1);

    // Every entry into a timed state happens on an accepted byte, so clearing on
    // accept (and while disabled) also covers the clear-on-state-entry rule.
    assign timer_en    = gap_counted(state);
    assign timer_clear = fire || !timer_en;

    // Decode the count byte: zero means a full memory, oversize N is rejected.
    always_comb begin
        n_too_big = (32'(rx_data) > 32'(MAX_WORDS));
        if (rx_data == 8'd0) begin
            n_decoded = MAX_WORDS;
        end else begin
            n_decoded = WC_W'(rx_data);
        end
    end

    gap_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    // Frame FSM with word assembly, checksum and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b1;
            imem_en   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            word_cnt  <= '0;
            n_words   <= '0;
            byte_idx  <= '0;
            word_reg  <= '0;
            csum      <= '0;
        end else begin
            imem_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fire && (rx_data == SYNC)) begin
                        state <= S_COUNT;
                    end
                end

                S_COUNT: begin
                    if (fire) begin
                        word_cnt <= '0;
                        csum     <= '0;
                        byte_idx <= '0;
                        n_words  <= n_decoded;
                        if (n_too_big) begin
                            state    <= S_ERROR;
                            rx_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end else if (timer_expired) begin
                        state    <= S_ERROR;
                        rx_ready <= 1'b0;
                        err      <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (fire) begin
                        csum     <= csum + rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // First byte ends up in [7:0] after three right shifts.
                            imem_en   <= 1'b1;
                            imem_addr <= word_cnt[ADDR_W-1:0];
                            imem_data <= {rx_data, word_reg};
                            word_cnt  <= word_cnt_inc;
                            if (word_cnt_inc == n_words) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            word_reg <= {rx_data, word_reg[23:8]};
                        end
                    end else if (timer_expired) begin
                        state    <= S_ERROR;
                        rx_ready <= 1'b0;
                        err      <= 1'b1;
                    end
                end

                S_CHECK: begin
                    if (fire) begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end else if (timer_expired) begin
                        state    <= S_ERROR;
                        rx_ready <= 1'b0;
                        err      <= 1'b1;
                    end
                end

                S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_IDLE;
                        rx_ready <= 1'b1;
                        cpu_rst  <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    rx_ready <= 1'b1;
                    cpu_rst  <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                end
            endcase
        end
    end

endmodule
